// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the multicycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative datapath: radix-2 Booth multiply and restoring signed divide,
// one step per cycle, with a down-counter flagging the final step.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 op_div,
  input  logic                 run,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 last,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  // acc is one bit wider than the operand so Booth add/sub of the most
  // negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bit_q, bit_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0]   sum, shifted, diff;

  // Load operands or advance one iteration; also form the final result
  // from the post-step values so the top can capture it on the last edge.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    mag_a   = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    mag_b   = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
    sum     = acc_q;
    shifted = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
    diff    = shifted - mcand_q;
    case ({sr_q[0], bit_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase

    if (load) begin
      acc_d = '0;
      bit_d = 1'b0;
      div_d = op_div;
      cnt_d = CW'(WIDTH - 1);
      if (op_div) begin
        sr_d    = mag_a;
        mcand_d = {1'b0, mag_b};
        negq_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
        negr_d  = a_in[WIDTH-1];
      end else begin
        sr_d    = b_in;
        mcand_d = {a_in[WIDTH-1], a_in};
        negq_d  = 1'b0;
        negr_d  = 1'b0;
      end
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        acc_d = diff[WIDTH] ? shifted : diff;
        sr_d  = {sr_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        sr_d  = {sum[0], sr_q[WIDTH-1:1]};
        bit_d = sr_q[0];
      end
    end

    // Magnitude divide then sign fix: quotient truncates toward zero,
    // remainder follows the dividend.
    quo    = negq_q ? (~sr_d + 1'b1) : sr_d;
    rem    = negr_q ? (~acc_d[WIDTH-1:0] + 1'b1) : acc_d[WIDTH-1:0];
    result = div_q ? {quo, rem} : {acc_d[WIDTH-1:0], sr_d};
  end

  assign last = (cnt_q == '0);

  // Datapath registers; clear returns the counter to zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      acc_q   <= '0;
      mcand_q <= '0;
      sr_q    <= '0;
      bit_q   <= 1'b0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU top: control FSM, single-cycle operations and result
// registers; multiply/divide iterations are delegated to muldiv_iter.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | Booth multiply iterating, busy
// DIV   | divide iterating, busy
// FIN   | result/flags valid, done pulse, new start accepted
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic                 illegal_op
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 dz_q, dz_d, ill_q, ill_d;

  logic                 md_load, md_run, md_last;
  logic [2*WIDTH-1:0]   md_result;

  logic [WIDTH-1:0]     alu_res, sra_res;
  logic                 alu_ill, b_big;
  logic [2*WIDTH-1:0]   rot_r, rot_l;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .clear  (clear),
    .load   (md_load),
    .op_div (opcode == OP_DIV),
    .run    (md_run),
    .a_in   (A),
    .b_in   (B),
    .last   (md_last),
    .result (md_result)
  );

  // Single-cycle operation results straight from the live inputs.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    b_big   = (B >= WIDTH'(WIDTH));
    rot_r   = {A, A} >> B[SW-1:0];
    rot_l   = {A, A} << B[SW-1:0];
    sra_res = $signed(A) >>> B;
    case (opcode)
      OP_ADD, OP_ADDI: alu_res = A + B;
      OP_SUB:          alu_res = A - B;
      OP_AND, OP_ANDI: alu_res = A & B;
      OP_OR, OP_ORI:   alu_res = A | B;
      OP_NOT:          alu_res = ~A;
      OP_NEG:          alu_res = ~A + 1'b1;
      OP_ROR:          alu_res = rot_r[WIDTH-1:0];
      OP_ROL:          alu_res = rot_l[2*WIDTH-1:WIDTH];
      OP_SHR:          alu_res = b_big ? '0 : (A >> B);
      OP_SHL:          alu_res = b_big ? '0 : (A << B);
      OP_SHRA:         alu_res = b_big ? {WIDTH{A[WIDTH-1]}} : sra_res;
      OP_MUL, OP_DIV:  alu_res = '0;
      default:         alu_ill = 1'b1;
    endcase
  end

  // Next-state, iteration control and result capture.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dz_d    = dz_q;
    ill_d   = ill_q;
    md_load = 1'b0;
    md_run  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start) begin
          if (opcode == OP_MUL) begin
            state_d = ST_MUL;
            md_load = 1'b1;
          end else if (opcode == OP_DIV && B != '0) begin
            state_d = ST_DIV;
            md_load = 1'b1;
          end else if (opcode == OP_DIV) begin
            state_d = ST_FIN;
            c_d     = {{WIDTH{1'b1}}, A};
            dz_d    = 1'b1;
            ill_d   = 1'b0;
          end else begin
            state_d = ST_FIN;
            c_d     = {{WIDTH{1'b0}}, alu_res};
            dz_d    = 1'b0;
            ill_d   = alu_ill;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        md_run = 1'b1;
        if (md_last) begin
          state_d = ST_FIN;
          c_d     = md_result;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; clear overrides everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign C          = c_q;
  assign busy       = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done       = (state_q == ST_FIN);
  assign div_zero   = dz_q;
  assign illegal_op = ill_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; power of two, 8..64.
REQ-002 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port opcode  input  5  operation select, encodings per REQ-040.
REQ-006 SHALL have port A  input  WIDTH  first operand (Y register side).
REQ-007 SHALL have port B  input  WIDTH  second operand / shift amount.
REQ-008 SHALL have port C  output  2*WIDTH  registered result; held between completions.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when C is updated.
REQ-011 SHALL have port div_zero  output  1  last completed DIV had B=0; held with C.
REQ-012 SHALL have port illegal_op  output  1  last completed opcode was unassigned; held with C.

Function
REQ-013 SHALL latch A, B, opcode on the edge where start=1 and busy=0; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1 (no restart, no queueing).
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIN; IDLE->MUL on MUL start, IDLE->DIV on DIV start (B!=0), IDLE->FIN on any other start, MUL/DIV->FIN after WIDTH iterations, FIN->IDLE unconditionally.
REQ-016 SHALL assert busy in MUL and DIV states only; done SHALL be 1 exactly in the FIN cycle, with C/flags valid in that same cycle.
REQ-017 SHALL give latency 1 edge (start edge to FIN) for single-cycle ops and div-by-zero, WIDTH+1 edges for MUL and DIV.
REQ-018 SHALL accept a new start during the FIN cycle (back-to-back, no idle gap required).
REQ-019 ADD, ADDI: C = {0, (A+B) mod 2^WIDTH}; SUB: C = {0, (A-B) mod 2^WIDTH}.
REQ-020 AND/ANDI, OR/ORI, NOT(A), NEG(A, two's complement): result in low half, upper half 0.
REQ-021 ROR/ROL SHALL rotate A by B mod WIDTH; SHR/SHL by B with result 0 when B>=WIDTH; SHRA by B with sign fill, all-sign-bits when B>=WIDTH.
REQ-022 MUL SHALL be signed radix-2 Booth, one iteration per cycle, C = full 2*WIDTH signed product.
REQ-023 DIV SHALL be signed non-restoring/restoring, one quotient bit per cycle, truncation toward zero, remainder sign = dividend sign; C = {quotient, remainder}.
REQ-024 DIV with B=0 SHALL complete in 1 edge with C = {all ones, A}, div_zero=1.
REQ-025 DIV of most-negative by -1 SHALL give quotient = most-negative, remainder 0, div_zero=0.
REQ-026 Unassigned opcode SHALL complete in 1 edge with C=0, illegal_op=1.
REQ-027 Each completion SHALL rewrite div_zero and illegal_op (clear when not applicable).

Reset
REQ-028 clear=1 SHALL on the next edge force IDLE, C=0, busy=0, done=0, div_zero=0, illegal_op=0, iteration counter 0.
REQ-029 clear SHALL take priority over start and abort any MUL/DIV in progress with no done pulse.
REQ-030 start asserted together with clear SHALL be discarded.

Structure
REQ-040 Opcode encodings SHALL live in shared package alu_pkg: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010; plus FSM state type.
REQ-041 Iterative multiply/divide datapath (accumulator, shift register, counter) SHALL be one sub-module, muldiv_iter; FSM and single-cycle ops stay in the top.

Verification (WIDTH=32)
REQ-050 MUL A=-3, B=7 -> done 33 edges after start, C=64'hFFFFFFFF_FFFFFFEB, busy high for cycles 1..32.
REQ-051 DIV A=17, B=-5 -> done after 33 edges, C={32'hFFFFFFFD, 32'h00000002}; then DIV A=32'h80000000, B=-1 -> C={32'h80000000, 0}.
REQ-052 DIV A=9, B=0 -> done after 1 edge, C={32'hFFFFFFFF, 32'h00000009}, div_zero=1; following ADD 2+3 -> C=5, div_zero=0.
REQ-053 SHRA A=32'h80000000, B=4 -> C low=32'hF8000000; SHR same -> 32'h08000000; SHL B=40 -> 0; ROL A=32'h80000001, B=33 -> 32'h00000003.
REQ-054 MUL start, clear at cycle 10 -> no done pulse, C=0, busy=0; start pulse while busy and opcode 11111 -> ignored while busy, then illegal_op=1, C=0.
